// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART-fed instruction memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_uart_loader_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;

    // Word count header length in bytes, sent MSB first.
    localparam int HDR_BYTES = 2;
    localparam int LEN_W     = HDR_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Bundles the loader's control, UART byte stream and memory write port.
// Latency: n/a (wires only).
// Backpressure: none; the UART strobe and memory port are push-only.
interface imem_uart_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  cpu_hold;
    logic                  busy;
    logic                  load_done;
    logic                  load_error;

    // Loader side.
    modport slave (
        input  start, rx_data, rx_done,
        output mem_we, mem_addr, mem_data, cpu_hold, busy, load_done, load_error
    );

    // Environment side (UART receiver, memory, CPU control).
    modport master (
        output start, rx_data, rx_done,
        input  mem_we, mem_addr, mem_data, cpu_hold, busy, load_done, load_error
    );
endinterface

// File: rtl/imem_uart_loader_word_assembler.sv
// Packs incoming bytes MSB-first into a word and flags the final byte.
// Latency: word_dat_o/word_rdy_o are combinational with the last byte strobe.
// Backpressure: none; every byte_vld_i is consumed.
module imem_uart_loader_word_assembler
    import imem_uart_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear_i,
    input  logic                  byte_vld_i,
    input  logic [7:0]            byte_dat_i,
    output logic [DATA_WIDTH-1:0] word_dat_o,
    output logic                  word_rdy_o
);
    localparam int BPW   = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    // The word including the byte on the wire this cycle, so the owner can
    // capture the complete word on the same edge as the last byte.
    assign word_dat_o = (shift_q << 8) | DATA_WIDTH'(byte_dat_i);
    assign word_rdy_o = byte_vld_i && (idx_q == IDX_W'(BPW - 1));

    // Shift in each accepted byte; the index wraps after a full word.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (byte_vld_i) begin
            shift_d = word_dat_o;
            idx_d   = word_rdy_o ? '0 : idx_q + 1'b1;
        end
    end

    // Assembly state registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a UART program image (16-bit word count + big-endian words) into imem port A.
// Latency: mem_we the cycle after a word's last byte; load_done one cycle after that.
// Backpressure: none; the UART cannot be stalled, so every strobe in a load state is consumed.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic               clock,
    input  logic               reset_n,
    imem_uart_loader_if.slave  ldr
);
    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  err_q, err_d;

    logic                  asm_clear;
    logic                  asm_byte_vld;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  asm_word_rdy;
    logic [LEN_W-1:0]      len_word;

    assign asm_byte_vld = ldr.rx_done && (state_q == ST_DATA);
    assign len_word     = {len_hi_q, ldr.rx_data};

    imem_uart_loader_word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (asm_clear),
        .byte_vld_i (asm_byte_vld),
        .byte_dat_i (ldr.rx_data),
        .word_dat_o (asm_word),
        .word_rdy_o (asm_word_rdy)
    );

    // Next-state logic: header parsing, word writes and end-of-image detection.
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_data_d  = mem_data_q;
        err_d       = err_q;
        asm_clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (ldr.start) begin
                    state_d   = ST_LEN_HI;
                    err_d     = 1'b0;
                    addr_d    = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (ldr.rx_done) begin
                    len_hi_d = ldr.rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (ldr.rx_done) begin
                    remaining_d = len_word;
                    if (len_word == '0) begin
                        state_d = ST_DONE;
                    end else if (int'(len_word) > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (asm_word_rdy) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = asm_word;
                end
                // Address and count advance at the end of the write cycle so
                // mem_addr is stable for the whole mem_we pulse. A full memory
                // wraps the address back to 0 on the final, unused increment.
                if (mem_we_q) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and memory-interface registers; reset abandons any load in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_data_q  <= mem_data_d;
            err_q       <= err_d;
        end
    end

    assign ldr.mem_we     = mem_we_q;
    assign ldr.mem_addr   = addr_q;
    assign ldr.mem_data   = mem_data_q;
    assign ldr.cpu_hold   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA);
    assign ldr.busy       = (state_q != ST_IDLE);
    assign ldr.load_done  = (state_q == ST_DONE);
    assign ldr.load_error = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: cycle vector table, corner sequences, randomized loads.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_uart_loader;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NV = 15;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    imem_uart_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    imem_uart_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ldr     (ifc)
    );

    typedef struct packed {
        logic          st;
        logic          rx;
        logic [7:0]    b;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          hold;
        logic          busy;
        logic          done;
        logic          err;
    } vec_t;

    vec_t vt [NV];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int last_we_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Log every memory write and load_done pulse, sampled mid-cycle.
    always @(negedge clock) begin
        if (ifc.mem_we === 1'b1) begin
            wa_q.push_back(ifc.mem_addr);
            wd_q.push_back(ifc.mem_data);
            last_we_cyc = cyc;
        end
        if (ifc.load_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic vec_t mk(input logic st, input logic rx, input logic [7:0] b,
                                input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic h, input logic bs, input logic dn, input logic er);
        vec_t v;
        v.st = st; v.rx = rx; v.b = b; v.we = we; v.addr = a; v.data = d;
        v.hold = h; v.busy = bs; v.done = dn; v.err = er;
        return v;
    endfunction

    function automatic logic [63:0] pack(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                         input logic h, input logic bs, input logic dn, input logic er);
        return 64'({we, a, d, h, bs, dn, er});
    endfunction

    function automatic logic [63:0] outs();
        return pack(ifc.mem_we, ifc.mem_addr, ifc.mem_data, ifc.cpu_hold, ifc.busy,
                    ifc.load_done, ifc.load_error);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        ifc.rx_data = b;
        ifc.rx_done = 1'b1;
        tick();
        last_rx_cyc = cyc;
        ifc.rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
        check({name, " done_count"}, 64'(done_cnt), 64'd1);
        tick();
        tick();
    endtask

    // Expected writes come straight from the image: word i lands at address i mod 2**AW.
    task automatic check_writes(input string name, input logic [DW-1:0] words [$]);
        check({name, " write_count"}, 64'(wa_q.size()), 64'(words.size()));
        for (int i = 0; i < words.size() && i < wa_q.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), 64'(wa_q[i]), 64'(i % (1 << AW)));
            check($sformatf("%s data[%0d]", name, i), 64'(wd_q[i]), 64'(words[i]));
        end
    endtask

    task automatic run_load(input string name, input logic [DW-1:0] words [$], input int maxgap);
        int n;
        n = words.size();
        clear_log();
        pulse_start();
        send(8'(n >> 8), $urandom_range(0, maxgap));
        send(8'(n), (n == 0) ? 0 : $urandom_range(0, maxgap));
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                send(8'(words[w] >> (24 - 8 * b)),
                     (w == n - 1 && b == 3) ? 0 : $urandom_range(0, maxgap));
            end
        end
        wait_done(name);
        check_writes(name, words);
        if (n > 0) check({name, " we_latency"}, 64'(last_we_cyc - last_rx_cyc), 64'd0);
        check({name, " done_latency"}, 64'(done_cyc - last_rx_cyc), (n > 0) ? 64'd1 : 64'd0);
        check({name, " load_error"}, 64'(ifc.load_error), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] img [$];

        ifc.start   = 1'b0;
        ifc.rx_done = 1'b0;
        ifc.rx_data = 8'h00;
        reset_n     = 1'b0;
        tick();
        tick();
        check("reset outputs", outs(), 64'd0);
        reset_n = 1'b1;
        tick();

        // Nominal two-word load, bytes back to back including the write cycle.
        vt[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        vt[2]  = mk(1'b0, 1'b1, 8'h02, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        vt[3]  = mk(1'b0, 1'b1, 8'h20, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        vt[4]  = mk(1'b0, 1'b1, 8'h08, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        vt[5]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 10'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b1, 8'h05, 1'b1, 10'd0, 32'h20080005, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[7]  = mk(1'b0, 1'b1, 8'h08, 1'b0, 10'd1, 32'h20080005, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[8]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 10'd1, 32'h20080005, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[9]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 10'd1, 32'h20080005, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[10] = mk(1'b0, 1'b1, 8'h00, 1'b1, 10'd1, 32'h08000000, 1'b1, 1'b1, 1'b0, 1'b0);
        vt[11] = mk(1'b0, 1'b0, 8'h00, 1'b0, 10'd2, 32'h08000000, 1'b0, 1'b1, 1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 8'h00, 1'b0, 10'd2, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[13] = mk(1'b0, 1'b1, 8'h55, 1'b0, 10'd2, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[14] = mk(1'b0, 1'b1, 8'hAA, 1'b0, 10'd2, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NV; i++) begin
            ifc.start   = vt[i].st;
            ifc.rx_done = vt[i].rx;
            ifc.rx_data = vt[i].b;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  pack(vt[i].we, vt[i].addr, vt[i].data, vt[i].hold, vt[i].busy, vt[i].done, vt[i].err));
        end
        ifc.start   = 1'b0;
        ifc.rx_done = 1'b0;
        tick();

        // Zero word count: done right after the header, nothing written.
        clear_log();
        pulse_start();
        send(8'h00, 2);
        send(8'h00, 0);
        check("zero load_done", 64'(ifc.load_done), 64'd1);
        check("zero load_error", 64'(ifc.load_error), 64'd0);
        tick();
        check("zero idle busy", 64'(ifc.busy), 64'd0);
        check("zero writes", 64'(wa_q.size()), 64'd0);

        // Oversize header, then recovery from ERROR with a one-word image.
        clear_log();
        pulse_start();
        send(8'h04, 0);
        send(8'h01, 0);
        check("oversize err/hold/busy", {ifc.load_error, ifc.cpu_hold, ifc.busy}, 64'b101);
        send(8'h00, 0);
        send(8'h01, 3);
        check("oversize stays error", {ifc.load_error, ifc.busy, ifc.mem_we}, 64'b110);
        check("oversize writes", 64'(wa_q.size()), 64'd0);
        pulse_start();
        check("restart clears error", {ifc.load_error, ifc.cpu_hold}, 64'b01);
        send(8'h00, 0);
        send(8'h01, 1);
        send(8'hDE, 0);
        send(8'hAD, 1);
        send(8'hBE, 0);
        send(8'hEF, 0);
        wait_done("recover");
        img = '{32'hDEADBEEF};
        check_writes("recover", img);

        // Reset partway through the second word of a four-word image.
        clear_log();
        pulse_start();
        send(8'h00, 0);
        send(8'h04, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        reset_n   = 1'b0;
        ifc.start = 1'b1;
        tick();
        check("midreset outputs", outs(), 64'd0);
        tick();
        check("midreset start ignored", outs(), 64'd0);
        ifc.start = 1'b0;
        reset_n   = 1'b1;
        tick();
        send(8'hCC, 0);
        send(8'hDD, 1);
        check("after reset idle", outs(), 64'd0);
        img = '{32'h11223344};
        check_writes("midreset", img);

        // Stray start during DATA and stray bytes in IDLE change nothing.
        clear_log();
        pulse_start();
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'hCA, 0);
        send(8'hFE, 0);
        send(8'hF0, 0);
        send(8'h0D, 0);
        send(8'h12, 1);
        pulse_start();
        check("stray start addr/hold/busy", {ifc.mem_addr, ifc.cpu_hold, ifc.busy}, {10'd1, 2'b11});
        send(8'h34, 0);
        send(8'h56, 2);
        send(8'h78, 0);
        wait_done("stray");
        send(8'h99, 0);
        send(8'h98, 0);
        check("idle bytes ignored", {ifc.busy, ifc.mem_addr}, {1'b0, 10'd2});
        img = '{32'hCAFEF00D, 32'h12345678};
        check_writes("stray", img);

        // Randomized images with random inter-byte gaps.
        for (int it = 0; it < 20; it++) begin
            img.delete();
            for (int w = 0; w < $urandom_range(0, 8); w++) img.push_back($urandom);
            run_load($sformatf("rand%0d", it), img, 2);
        end

        // Full memory: exactly 2**AW words, address wraps to 0 afterwards.
        img.delete();
        for (int w = 0; w < (1 << AW); w++) img.push_back($urandom);
        run_load("full", img, 0);
        check("full addr wrap", 64'(ifc.mem_addr), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
